// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch unit: FSM state encoding, queue entry layout
// and the IM word-address width.
package ifetch_pkg;

    localparam int IM_AW = 16;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Synchronous FIFO of fetch entries with push/pop/flush; head is presented combinationally
// and reads as zero while the queue is empty.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  fetch_entry_t             push_entry_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic                     empty_o,
    output logic [$clog2(QDEPTH):0]  count_o,
    output fetch_entry_t             head_o
);

    localparam int PW = $clog2(QDEPTH);

    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW:0]   cnt_q, cnt_d;
    fetch_entry_t  mem_q [QDEPTH];

    // Pointers wrap naturally because QDEPTH is a power of two.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + 1'b1;
            if (pop_i)  rd_d = rd_q + 1'b1;
            if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
            else if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= push_entry_i;
    end

    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: reads IM combinationally, queues {pc, inst} for decode,
// handles redirect flush, halt and backpressure. Define BOOT_LOAD_EN to enable IM boot loading.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              IM_enable,
    output logic              IM_write,
    output logic [IM_AW-1:0]  IM_address,
    output logic [31:0]       IM_in,
    input  logic [31:0]       IM_out,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              halt,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [31:0]       inst_pc,
    input  logic              boot_valid,
    input  logic [31:0]       boot_data,
    input  logic              boot_done
);

    localparam logic [1:0] ST_BOOT   = BOOT;
    localparam logic [1:0] ST_FETCH  = FETCH;
    localparam logic [1:0] ST_HALTED = HALTED;
    localparam int         CW        = $clog2(QDEPTH) + 1;

`ifdef BOOT_LOAD_EN
    localparam logic [1:0] RESET_ST = ST_BOOT;
`else
    localparam logic [1:0] RESET_ST = ST_FETCH;
`endif

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          q_empty;
    logic [CW-1:0] q_count;
    logic          pop, flush, fetch;
    fetch_entry_t  push_entry, head;

    assign inst_valid = rst && !q_empty;
    assign pop        = inst_valid && inst_ready;
    assign flush      = rst && redirect_valid && (state_q == ST_FETCH || state_q == ST_HALTED);
    // A pop frees a slot in the same cycle, so a full queue still streams one inst per cycle.
    assign fetch      = rst && (state_q == ST_FETCH) && !halt && !redirect_valid &&
                        ((q_count < CW'(QDEPTH)) || pop);
    assign push_entry = '{pc: pc_q, inst: IM_out};
    assign inst_data  = inst_valid ? head.inst : '0;
    assign inst_pc    = inst_valid ? head.pc   : '0;

    ifetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk          (clk),
        .rst          (rst),
        .push_i       (fetch),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (flush),
        .empty_o      (q_empty),
        .count_o      (q_count),
        .head_o       (head)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (flush)      pc_d = {redirect_pc[31:2], 2'b00};
        else if (fetch) pc_d = pc_q + 32'd4;
        case (state_q)
`ifdef BOOT_LOAD_EN
            ST_BOOT:   if (boot_done) state_d = ST_FETCH;
`else
            ST_BOOT:   state_d = ST_FETCH;
`endif
            ST_FETCH:  if (halt) state_d = ST_HALTED;
            ST_HALTED: if (!halt && !redirect_valid) state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RESET_ST;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef BOOT_LOAD_EN
    logic [IM_AW-1:0] boot_ptr_q, boot_ptr_d;
    logic             boot_wr;

    assign boot_wr    = rst && (state_q == ST_BOOT) && boot_valid;
    assign boot_ptr_d = boot_wr ? boot_ptr_q + 1'b1 : boot_ptr_q;

    always_ff @(posedge clk) begin
        if (!rst) boot_ptr_q <= RESET_PC[IM_AW+1:2];
        else      boot_ptr_q <= boot_ptr_d;
    end
`else
    logic unused_boot;
    assign unused_boot = ^{boot_valid, boot_data, boot_done};
`endif

    always_comb begin
        IM_enable  = 1'b0;
        IM_write   = 1'b0;
        IM_address = '0;
        IM_in      = '0;
        if (fetch) begin
            IM_enable  = 1'b1;
            IM_address = pc_q[IM_AW+1:2];
        end
`ifdef BOOT_LOAD_EN
        if (boot_wr) begin
            IM_enable  = 1'b1;
            IM_write   = 1'b1;
            IM_address = boot_ptr_q;
            IM_in      = boot_data;
        end
`endif
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a sequential-program reference model feeds an expected-entry queue,
// a negedge monitor compares every delivered instruction against it.
module tb_ifetch_unit;
    import ifetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              IM_enable, IM_write;
    logic [IM_AW-1:0]  IM_address;
    logic [31:0]       IM_in, IM_out;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              halt;
    logic              inst_valid, inst_ready;
    logic [31:0]       inst_data, inst_pc;
    logic              boot_valid, boot_done;
    logic [31:0]       boot_data;

    ifetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .IM_enable      (IM_enable),
        .IM_write       (IM_write),
        .IM_address     (IM_address),
        .IM_in          (IM_in),
        .IM_out         (IM_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .boot_valid     (boot_valid),
        .boot_data      (boot_data),
        .boot_done      (boot_done)
    );

    always #5 clk = ~clk;

    // Environment memory and the bench's own copy of what the program image should be.
    logic [31:0] im        [0:65535];
    logic [31:0] model_mem [0:65535];
    assign IM_out = im[IM_address];
    always @(posedge clk) if (IM_enable && IM_write) im[IM_address] <= IM_in;

    int n_chk = 0, n_pass = 0;
    int n_fetch = 0, delivered = 0, base;
    bit mon_en = 1'b0;
    fetch_entry_t exp_q[$];
    logic [31:0] gen_pc;
    bit          redir_pend = 1'b0;
    logic [31:0] redir_tgt;

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    function automatic logic [31:0] model_inst(input logic [31:0] pc);
        return model_mem[pc[17:2]];
    endfunction

    // The delivered stream is the program in address order from the last reset/redirect target.
    task automatic topup();
        while (exp_q.size() < 16) begin
            exp_q.push_back('{pc: gen_pc, inst: model_inst(gen_pc)});
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        gen_pc = pc;
        topup();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (redir_pend) begin
            redir_pend = 1'b0;
            restart(redir_tgt);
        end
        topup();
    endtask

    task automatic redirect(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        redir_pend     = 1'b1;
        redir_tgt      = {t[31:2], 2'b00};
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (IM_enable && !IM_write) n_fetch++;
`ifndef BOOT_LOAD_EN
            check("im_write_idle", !IM_write && IM_in == 32'd0, {IM_write, IM_in}, 64'd0);
`endif
            if (inst_valid && inst_ready) begin
                check("sb_nonempty", exp_q.size() != 0, exp_q.size(), 1);
                if (exp_q.size() != 0) begin
                    fetch_entry_t e;
                    e = exp_q.pop_front();
                    delivered++;
                    check("sb_pc", inst_pc == e.pc, inst_pc, e.pc);
                    check("sb_data", inst_data == e.inst, inst_data, e.inst);
                end
            end else if (!inst_valid) begin
                check("idle_zero", inst_pc == 32'd0 && inst_data == 32'd0, {inst_pc, inst_data}, 64'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            im[i]        = 32'h100 + i;
            model_mem[i] = 32'h100 + i;
        end
        rst = 1'b0; inst_ready = 1'b0; halt = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        boot_valid = 1'b0; boot_data = '0; boot_done = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_im_enable", !IM_enable && !IM_write && IM_in == 32'd0, {IM_enable, IM_write}, 0);
        check("rst_inst_valid", !inst_valid, inst_valid, 0);

        @(posedge clk); #1;
        rst = 1'b1;
        restart(RESET_PC);

`ifdef BOOT_LOAD_EN
        for (int i = 0; i < 3; i++) begin
            boot_valid = 1'b1;
            boot_data  = 32'hA + i;
            boot_done  = (i == 2);
            @(negedge clk);
            check("boot_write", IM_enable && IM_write && IM_address == i[15:0] && IM_in == 32'hA + i,
                  {IM_enable, IM_write, IM_address, IM_in}, {2'b11, i[15:0], 32'hA + i});
            model_mem[RESET_PC[17:2] + i] = 32'hA + i;
            tick();
        end
        boot_valid = 1'b0; boot_done = 1'b0;
        restart(RESET_PC);
`endif

        // Decode stalled: only QDEPTH fetches may be issued.
        base = n_fetch;
        repeat (10) tick();
        check("stall_fetches", n_fetch - base == 4, n_fetch - base, 4);
        check("stall_full", inst_valid && !IM_enable, {inst_valid, IM_enable}, 2'b10);
        inst_ready = 1'b1;
        repeat (8) tick();

        // Redirect over a full queue; the target's low bits are dropped.
        inst_ready = 1'b0;
        repeat (6) tick();
        inst_ready = 1'b1;
        redirect(32'h42);
        tick();
        @(negedge clk);
        check("redir_fetch", IM_enable && IM_address == 16'h10, IM_address, 16'h10);
        check("redir_gap", !inst_valid, inst_valid, 0);
        tick();
        @(negedge clk);
        check("redir_first", inst_valid && inst_pc == 32'h40, inst_pc, 32'h40);
        repeat (5) tick();

        // Halt: no IM accesses, queue drains, resume at the frozen pc.
        halt = 1'b1;
        base = n_fetch;
        repeat (5) tick();
        check("halt_no_fetch", n_fetch == base, n_fetch - base, 0);
        check("halt_drained", !inst_valid, inst_valid, 0);
        halt = 1'b0;
        tick();
        @(negedge clk);
        check("resume_addr", IM_enable && IM_address == exp_q[0].pc[17:2], IM_address, exp_q[0].pc[17:2]);
        repeat (4) tick();

        // Address wrap at the top of the 32-bit PC space.
        redirect(32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        check("wrap_addr_hi", IM_enable && IM_address == 16'hFFFF, IM_address, 16'hFFFF);
        tick();
        @(negedge clk);
        check("wrap_addr_lo", IM_enable && IM_address == 16'h0000, IM_address, 16'h0000);
        check("wrap_pc_hi", inst_valid && inst_pc == 32'hFFFF_FFFC, inst_pc, 32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        check("wrap_pc_lo", inst_valid && inst_pc == 32'h0, inst_pc, 32'h0);
        tick();

        // Random traffic with a reset in the middle.
        for (int c = 0; c < 1500; c++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            boot_done  = 1'b0;
            if (c == 700) begin
                rst        = 1'b0;
                halt       = 1'b0;
                redir_pend = 1'b0;
                restart(RESET_PC);
            end else if (c == 702) begin
                rst       = 1'b1;
                boot_done = 1'b1;
            end else if (rst && c != 703 && $urandom_range(0, 24) == 0) begin
                redirect($urandom);
            end
            if (c != 700 && $urandom_range(0, 19) == 0) halt = ~halt;
            tick();
        end
        halt = 1'b0;
        inst_ready = 1'b1;
        repeat (20) tick();
        check("delivered_min", delivered >= 200, delivered, 200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
